instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/tsp_pkg.sv | 17 +
 rtl/ifetch_skid_fifo.sv | 73 +++++++
 rtl/instruction_fetch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/tsp_pkg.sv
// Shared definitions for the instruction fetch slice: default widths,
// fetch FSM state encoding and the end-of-program (NOP) word.
package tsp_pkg;

  localparam int DEF_INSTR_WIDTH          = 32;
  localparam int DEF_INSTR_MEM_ADDR_WIDTH = 10;

  // Word the memory returns at the end of a program.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ifetch_state_e;

endpackage

// File: rtl/ifetch_skid_fifo.sv
// Two-entry output buffer between the fetch pipeline and the decoder.
// Holds {instruction, pc} pairs; the head is presented combinationally
// and stays stable until popped. Simultaneous push and pop are allowed,
// including push while full when the same cycle pops.
module ifetch_skid_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [PC_WIDTH-1:0]   push_pc,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [PC_WIDTH-1:0]   head_pc,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] data_q [2];
  logic [PC_WIDTH-1:0]   pc_q   [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  do_pop;
  logic                  do_push;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_data = data_q[rd_ptr_q];
  assign head_pc   = pc_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; flush empties the buffer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (rst || flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage written at the write pointer.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is reset on purpose so the head (and thus
    // instr/instr_pc) reads 0 out of reset instead of X; flush does not
    // clear it because instr_valid already masks stale entries.
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (do_push) begin
      data_q[wr_ptr_q] <= push_data;
      pc_q[wr_ptr_q]   <= push_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: streams words from a one-cycle-latency
// instruction memory into a two-entry buffer feeding the decoder, starting
// at start_addr and stopping at the first word flagged invalid (NOP).
// Optional feature macro: IFETCH_PERF_CNT_EN enables the saturating
// fetch_count counter; without it fetch_count is tied to 0.
module instruction_fetch
  import tsp_pkg::*;
#(
  parameter int INSTR_WIDTH          = DEF_INSTR_WIDTH,
  parameter int INSTR_MEM_ADDR_WIDTH = DEF_INSTR_MEM_ADDR_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [INSTR_MEM_ADDR_WIDTH-1:0] start_addr,
  output logic [INSTR_MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [INSTR_WIDTH-1:0]          mem_instr,
  input  logic                            mem_instr_valid,
  output logic [INSTR_WIDTH-1:0]          instr,
  output logic [INSTR_MEM_ADDR_WIDTH-1:0] instr_pc,
  output logic                            instr_valid,
  input  logic                            instr_ready,
  output logic                            busy,
  output logic                            done,
  output logic [15:0]                     fetch_count
);

  localparam logic [INSTR_MEM_ADDR_WIDTH-1:0] ADDR_ONE =
    {{(INSTR_MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};

  ifetch_state_e                   state_q, state_d;
  logic [INSTR_MEM_ADDR_WIDTH-1:0] mem_addr_q;
  logic [INSTR_MEM_ADDR_WIDTH-1:0] inflight_pc_q;
  logic                            inflight_q;
  logic                            issue;
  logic                            flush;
  logic                            push;
  logic                            pop;
  logic                            resp_nop;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [1:0]                      buffered;
  logic [2:0]                      occupancy;

  // A response exists only in the cycle after an issue.
  assign push     = inflight_q && mem_instr_valid;
  assign resp_nop = inflight_q && !mem_instr_valid;
  assign pop      = instr_valid && instr_ready;

  assign mem_addr    = mem_addr_q;
  assign instr_valid = !fifo_empty;
  assign busy        = (state_q != IDLE);

  // Words the buffer will hold next cycle if we issue now.
  always_comb begin
    buffered  = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    occupancy = {1'b0, buffered} + {2'b00, inflight_q} - {2'b00, pop};
  end

  // Fetch FSM next-state and control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    issue   = 1'b0;
    flush   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          flush   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Never issue past a NOP: the NOP response stops the stream.
        if (resp_nop) state_d = DRAIN;
        else if (occupancy < 3'd2) issue = 1'b1;
      end
      DRAIN: begin
        if (fifo_empty && !inflight_q) begin
          // A reset in this cycle aborts the program, so no completion.
          done    = !rst;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Read address, in-flight flag and the address of the outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q <= issue;
      if (flush)      mem_addr_q <= start_addr;
      else if (issue) mem_addr_q <= mem_addr_q + ADDR_ONE;
      if (issue) inflight_pc_q <= mem_addr_q;
    end
  end

  ifetch_skid_fifo #(
    .DATA_WIDTH (INSTR_WIDTH),
    .PC_WIDTH   (INSTR_MEM_ADDR_WIDTH)
  ) u_skid_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (mem_instr),
    .push_pc   (inflight_pc_q),
    .pop       (pop),
    .head_data (instr),
    .head_pc   (instr_pc),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef IFETCH_PERF_CNT_EN
  logic [15:0] fetch_count_q;

  // Accepted-transfer counter, cleared on start, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst || flush)                        fetch_count_q <= '0;
    else if (pop && fetch_count_q != 16'hFFFF) fetch_count_q <= fetch_count_q + 16'd1;
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

endmodule
